// File: rtl/riscv_muldiv.sv
// RV32M multiply/divide unit: iterative, one bit per cycle, IDLE/CALC/DONE.
// Ports: clk, rst (sync, active-high), start, op[2:0] (funct3), inA, inB,
//   flush, busy, done (1-cycle pulse), out[31:0] (held until next start).
// Macro RISCV_MULDIV_EARLY_OUT_EN: when defined, divide-by-zero, signed
//   overflow and multiply-by-zero finish one cycle after start.
module riscv_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic        r_fin;
  logic [2:0]  r_op;
  logic [31:0] r_ina;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic        r_neg;
  logic        r_divz;
  logic [31:0] r_out;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
  logic        r_early;
  logic        w_early;
`endif

  // operand decode at the accepting edge
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_neg;

  assign w_a_sgn = (op == 3'd1) || (op == 3'd2) ||
                   (op == 3'd4) || (op == 3'd6);
  assign w_b_sgn = (op == 3'd1) || (op == 3'd4) ||
                   (op == 3'd6);
  assign w_a_neg = w_a_sgn & inA[31];
  assign w_b_neg = w_b_sgn & inB[31];
  assign w_a_mag = w_a_neg ? (32'd0 - inA) : inA;
  assign w_b_mag = w_b_neg ? (32'd0 - inB) : inB;
  // remainder takes the dividend's sign; everything else the xor
  assign w_neg   = (op == 3'd6) ? w_a_neg : (w_a_neg ^ w_b_neg);

`ifdef RISCV_MULDIV_EARLY_OUT_EN
  assign w_early =
    (!op[2] && (inA == 32'd0 || inB == 32'd0)) ||
    (op[2] && inB == 32'd0) ||
    ((op == 3'd4 || op == 3'd6) &&
     inA == 32'h8000_0000 && inB == 32'hFFFF_FFFF);
`endif

  // shift-add step: {hi,lo} is the running product, lo holds multiplier
  logic [32:0] w_sum;
  assign w_sum = {1'b0, r_hi} +
                 (r_lo[0] ? {1'b0, r_b} : 33'd0);

  // restoring step: hi is the partial remainder, lo shifts dividend->quotient
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_diff;
  assign w_trial = {r_hi, r_lo[31]};
  assign w_ge    = w_trial >= {1'b0, r_b};
  assign w_diff  = w_trial[31:0] - r_b;

  // final sign correction and special cases
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_result;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
  assign w_q      = r_neg ? (32'd0 - r_lo) : r_lo;
  assign w_r      = r_neg ? (32'd0 - r_hi) : r_hi;

  always_comb begin
    w_result = 32'd0;
    case (r_op)
      3'd0:    w_result = w_prod_s[31:0];
      3'd1,
      3'd2,
      3'd3:    w_result = w_prod_s[63:32];
      3'd4,
      3'd5:    w_result = r_divz ? 32'hFFFF_FFFF : w_q;
      default: w_result = r_divz ? r_ina : w_r;
    endcase
  end

  logic w_last;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
  assign w_last = r_fin | r_early;
`else
  assign w_last = r_fin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_fin   <= 1'b0;
      r_op    <= 3'd0;
      r_ina   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_b     <= 32'd0;
      r_neg   <= 1'b0;
      r_divz  <= 1'b0;
      r_out   <= 32'd0;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
      r_early <= 1'b0;
`endif
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_fin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CALC;
            r_cnt   <= 5'd0;
            r_fin   <= 1'b0;
            r_op    <= op;
            r_ina   <= inA;
            r_hi    <= 32'd0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg   <= w_neg;
            r_divz  <= op[2] & (inB == 32'd0);
`ifdef RISCV_MULDIV_EARLY_OUT_EN
            r_early <= w_early;
            // zero product without iterating
            if (w_early && !op[2])
              r_lo <= 32'd0;
`endif
          end
        end
        S_CALC: begin
          if (w_last) begin
            r_out   <= w_result;
            r_state <= S_DONE;
            r_fin   <= 1'b0;
          end else begin
            if (!r_op[2]) begin
              r_hi <= w_sum[32:1];
              r_lo <= {w_sum[0], r_lo[31:1]};
            end else begin
              r_hi <= w_ge ? w_diff : w_trial[31:0];
              r_lo <= {r_lo[30:0], w_ge};
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31)
              r_fin <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign out  = r_out;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv with a cycle-level reference model.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] inA = 32'd0;
  logic [31:0] inB = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_vec = 0;
  int n_err = 0;

`ifdef RISCV_MULDIV_EARLY_OUT_EN
  localparam int LATZ = 1;
`else
  localparam int LATZ = 33;
`endif
  localparam int LAT = 33;

  always #5 clk = ~clk;

  riscv_muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    longint      p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    pu = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef RISCV_MULDIV_EARLY_OUT_EN
    if (!o[2]) return (a == 0) || (b == 0);
    if (b == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) &&
           a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
`else
    return 1'b0;
`endif
  endfunction

  // reference: 0 idle, 1 computing, 2 result cycle
  int          m_ph = 0;
  int          m_left = 0;
  logic [31:0] m_out = 32'd0;
  logic [31:0] m_pend = 32'd0;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph  = 0;
      m_out = 32'd0;
      m_on  = 1'b1;
    end else if (flush) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_pend = ref_res(op, inA, inB);
          m_left = is_fast(op, inA, inB) ? 1 : 33;
          m_ph   = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_ph  = 2;
            m_out = m_pend;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_ph != 0)});
      chk("done", {31'd0, done}, {31'd0, (m_ph == 2)});
      chk("out", out, m_out);
    end
  end

  task automatic run(input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit,
                     input int lat_exp, input bit noise,
                     input string nm);
    int lat;
    @(posedge clk);
    #2 start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clk);
    #2 start = 1'b0;
    chk({nm, " model"}, ref_res(o, a, b), lit);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (done === 1'b1) break;
      lat++;
      if (noise && lat == 5) begin
        start = 1'b1; op = 3'd0; inA = 32'd1; inB = 32'd1;
      end
      if (noise && lat == 8) start = 1'b0;
    end
    chk({nm, " lat"}, 32'(lat), 32'(lat_exp));
    chk({nm, " res"}, out, lit);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst out", out, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);

    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, LAT, 0, "mulh");
    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, LAT, 0, "mul");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, 0, "div");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, 0, "rem");
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, LATZ, 0, "divu0");
    run(3'd7, 32'd5, 32'd0, 32'd5, LATZ, 0, "remu0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
        LATZ, 0, "divovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,
        LATZ, 0, "removf");
    run(3'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, LAT, 0, "mulhsu");
    run(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, LATZ, 0, "div0");
    run(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, LATZ, 0, "rem0");
    run(3'd0, 32'd0, 32'd5, 32'd0, LATZ, 0, "mulz");
    run(3'd5, 32'd100, 32'd7, 32'd14, LAT, 1, "divu ign");
    run(3'd6, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, LAT, 0, "remneg");

    // flush at counter 10
    @(posedge clk);
    #2 start = 1'b1; op = 3'd5; inA = 32'd100; inB = 32'd7;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk);
    #2 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush out", out, 32'hFFFF_FFFE);

    // flush beats start
    @(posedge clk);
    #2 start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #2 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush+start busy", {31'd0, busy}, 32'd0);

    run(3'd3, 32'h8000_0000, 32'd4, 32'd2, LAT, 0, "mulhu");

    // reset mid-operation with start held high
    @(posedge clk);
    #2 start = 1'b1; op = 3'd0; inA = 32'd7; inB = 32'd9;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst out", out, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
